// File: rtl/stream_pkg.sv
// Shared defaults and state encoding for the stream source.
package stream_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_t;

endpackage

// File: rtl/stream_seq_gen.sv
// Arithmetic sequence accumulator and transfer counter for stream_source.
module stream_seq_gen
  import stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] stride,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] word,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] stride_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W:0]   count_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      count_q  <= '0;
    end else if (load) begin
      word_q   <= base;
      stride_q <= stride;
      len_q    <= len;
      count_q  <= '0;
    end else if (advance) begin
      word_q  <= word_q + stride_q;
      count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // One extra bit so the compare stays exact when len is all ones
  assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
  assign last      = (count_inc == {1'b0, len_q});
  assign word      = word_q;
  assign count     = count_q;

endmodule

// File: rtl/stream_source.sv
// Programmed arithmetic-sequence source on a valid/ready word channel.
//   state | meaning
//   IDLE  | waiting for start; channel idle
//   RUN   | presenting words, one per accepted transfer
//   DONE  | one-cycle done pulse after the last word
module stream_source
  import stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_base,
  input  logic [WIDTH-1:0] cfg_stride,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  state_t state_q, state_nxt;
  logic   load;
  logic   xfer;
  logic   last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_nxt;
  end

  // Outputs decode straight from the state register so reset clears them at once
  assign out_valid = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          load      = 1'b1;
          state_nxt = (cfg_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // Abort wins over completion; a coincident transfer still counts
        if (abort)             state_nxt = ST_IDLE;
        else if (xfer && last) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  stream_seq_gen #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_seq (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .advance(xfer),
    .base   (cfg_base),
    .stride (cfg_stride),
    .len    (cfg_len),
    .word   (out_data),
    .count  (sent_count),
    .last   (last)
  );

endmodule

// File: tb/tb_stream_source.sv
// Directed self-checking bench for stream_source.
module tb_stream_source;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_base;
  logic [15:0] cfg_stride;
  logic [15:0] cfg_len;
  logic        abort;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        busy;
  logic        done;
  logic [15:0] sent_count;

  int errors = 0;
  int checks = 0;

  stream_source dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_base  (cfg_base),
    .cfg_stride(cfg_stride),
    .cfg_len   (cfg_len),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .sent_count(sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] b, input logic [15:0] s, input logic [15:0] l);
    cfg_base = b; cfg_stride = s; cfg_len = l; start = 1'b1;
    step();
    start = 1'b0; cfg_base = 16'hDEAD; cfg_stride = 16'hBEEF; cfg_len = 16'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b done=%b exp=0/0", busy, done); end
    checks++; if (out_data !== 16'h0 || sent_count !== 16'h0) begin errors++; $display("FAIL reset_data data=%h cnt=%0d exp=0/0", out_data, sent_count); end
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [3];
    exp_d[0] = 16'd10; exp_d[1] = 16'd15; exp_d[2] = 16'd20;
    out_ready = 1'b1;
    launch(16'd10, 16'd5, 16'd3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== exp_d[i]) begin
        errors++; $display("FAIL basic_word%0d valid=%b busy=%b data=%0d exp=1/1/%0d", i, out_valid, busy, out_data, exp_d[i]);
      end
      step();
    end
    checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_done done=%b valid=%b exp=1/0", done, out_valid); end
    checks++; if (sent_count !== 16'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", sent_count); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_after done=%b busy=%b exp=0/0", done, busy); end
    checks++; if (sent_count !== 16'd3) begin errors++; $display("FAIL basic_hold got=%0d exp=3", sent_count); end
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || sent_count !== 16'd0) begin errors++; $display("FAIL basic_rst valid=%b cnt=%0d exp=0/0", out_valid, sent_count); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_d [4];
    exp_d[0] = 16'd1; exp_d[1] = 16'd2; exp_d[2] = 16'd3; exp_d[3] = 16'd4;
    out_ready = 1'b0;
    launch(16'd1, 16'd1, 16'd4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'd1 || sent_count !== 16'd0) begin
        errors++; $display("FAIL bp_stall%0d valid=%b data=%0d cnt=%0d exp=1/1/0", i, out_valid, out_data, sent_count);
      end
      if (i < 2) step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
        errors++; $display("FAIL bp_word%0d valid=%b data=%0d exp=1/%0d", i, out_valid, out_data, exp_d[i]);
      end
      step();
    end
    checks++; if (done !== 1'b1 || sent_count !== 16'd4) begin errors++; $display("FAIL bp_done done=%b cnt=%0d exp=1/4", done, sent_count); end
    step();
  endtask

  task automatic test_wrap();
    logic [15:0] exp_d [3];
    exp_d[0] = 16'hFFFE; exp_d[1] = 16'h0001; exp_d[2] = 16'h0004;
    out_ready = 1'b1;
    launch(16'hFFFE, 16'd3, 16'd3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
        errors++; $display("FAIL wrap_word%0d valid=%b data=%h exp=1/%h", i, out_valid, out_data, exp_d[i]);
      end
      step();
    end
    checks++; if (done !== 1'b1 || sent_count !== 16'd3) begin errors++; $display("FAIL wrap_done done=%b cnt=%0d exp=1/3", done, sent_count); end
    step();
  endtask

  task automatic test_zero_len();
    out_ready = 1'b1;
    launch(16'd9, 16'd1, 16'd0);
    checks++; if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done valid=%b done=%b busy=%b exp=0/1/0", out_valid, done, busy); end
    checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL zero_count got=%0d exp=0", sent_count); end
    step();
    checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL zero_after valid=%b done=%b exp=0/0", out_valid, done); end
  endtask

  task automatic test_abort();
    logic [15:0] exp_d [3];
    exp_d[0] = 16'd0; exp_d[1] = 16'd2; exp_d[2] = 16'd4;
    out_ready = 1'b1;
    launch(16'd0, 16'd2, 16'd10);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin
        errors++; $display("FAIL abort_word%0d valid=%b data=%0d exp=1/%0d", i, out_valid, out_data, exp_d[i]);
      end
      if (i == 2) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle valid=%b busy=%b done=%b exp=0/0/0", out_valid, busy, done); end
    checks++; if (sent_count !== 16'd3) begin errors++; $display("FAIL abort_count got=%0d exp=3", sent_count); end
    launch(16'd100, 16'd1, 16'd2);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd100 || sent_count !== 16'd0) begin errors++; $display("FAIL abort_restart valid=%b data=%0d cnt=%0d exp=1/100/0", out_valid, out_data, sent_count); end
    step();
    checks++; if (out_data !== 16'd101) begin errors++; $display("FAIL abort_restart2 got=%0d exp=101", out_data); end
    step();
    checks++; if (done !== 1'b1 || sent_count !== 16'd2) begin errors++; $display("FAIL abort_restart_done done=%b cnt=%0d exp=1/2", done, sent_count); end
    step();
  endtask

  task automatic test_abort_last();
    out_ready = 1'b1;
    launch(16'd0, 16'd1, 16'd2);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || sent_count !== 16'd2) begin errors++; $display("FAIL abort_last done=%b busy=%b cnt=%0d exp=0/0/2", done, busy, sent_count); end
    cfg_base = 16'd5; cfg_stride = 16'd1; cfg_len = 16'd3; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL start_abort busy=%b valid=%b done=%b exp=0/0/0", busy, out_valid, done); end
  endtask

  task automatic test_reset_midrun();
    out_ready = 1'b0;
    launch(16'd7, 16'd1, 16'd5);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd7) begin errors++; $display("FAIL rstmid_pre valid=%b data=%0d exp=1/7", out_valid, out_data); end
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'd0) begin errors++; $display("FAIL rstmid_async valid=%b busy=%b data=%0d exp=0/0/0", out_valid, busy, out_data); end
    step(); step();
    rst = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_idle valid=%b busy=%b done=%b exp=0/0/0", out_valid, busy, done); end
    launch(16'd3, 16'd1, 16'd1);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'd3) begin errors++; $display("FAIL rstmid_start valid=%b data=%0d exp=1/3", out_valid, out_data); end
    out_ready = 1'b1;
    step();
    checks++; if (done !== 1'b1 || sent_count !== 16'd1) begin errors++; $display("FAIL rstmid_done done=%b cnt=%0d exp=1/1", done, sent_count); end
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cfg_base = '0; cfg_stride = '0; cfg_len = '0;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_abort();
    test_abort_last();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
